vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 2: input clocks per pixel; legal values are 1 to 4.
REQ-002 Parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33: vertical timing in lines.
REQ-004 clk  in  1  system clock; one clock domain only.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 hours_in  in  4  live chronometer hours.
REQ-007 minutes_in  in  6  live minutes (0-59).
REQ-008 seconds_in  in  6  live seconds (0-59).
REQ-009 milliseconds_in  in  10  live milliseconds (0-999).
REQ-010 column  out  16  horizontal pixel counter, 0 to H_TOTAL-1 (H_TOTAL=800).
REQ-011 row  out  16  vertical line counter, 0 to V_TOTAL-1 (V_TOTAL=525).
REQ-012 enable  out  1  high when column<H_VISIBLE and row<V_VISIBLE.
REQ-013 hsync, vsync  out  1 each  active-low sync pulses.
REQ-014 pixel_tick  out  1  one-clk strobe on each clock where the counters advance.
REQ-015 frame_start  out  1  one-clk pulse on the clock where the counters wrap to (0,0).
REQ-016 hours, minutes, seconds, milliseconds  out  4/6/6/10  frame-stable snapshot of the *_in inputs, feeding the image drawer.

Function
REQ-017 The divider counter div shall count 0 to CLK_DIV-1 and then wrap; pixel_tick shall be 1 when div==CLK_DIV-1; with CLK_DIV=1, pixel_tick shall be constantly 1 outside reset.
REQ-018 On each pixel_tick, column shall increment; at column==H_TOTAL-1, column shall become 0 and row shall increment.
REQ-019 At column==H_TOTAL-1 and row==V_TOTAL-1, both counters shall become 0 on the same tick.
REQ-020 Counters shall hold their value on clocks without pixel_tick.
REQ-021 column and row shall be the counter registers driven directly, with no added latency.
REQ-022 hsync shall be 0 exactly when H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC (656 to 751), and 1 otherwise.
REQ-023 vsync shall be 0 exactly when V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (490 to 491), and 1 otherwise.
REQ-024 enable, hsync and vsync shall be combinational decodes of the current counter values.
REQ-025 frame_start shall be a registered pulse, high for exactly one clk following the wrap tick of REQ-019.
REQ-026 Snapshot registers shall load all four *_in inputs together on the tick where row goes from V_VISIBLE-1 to V_VISIBLE (start of vertical blank).
REQ-027 Snapshot registers shall hold their value at all other times, so that values never change while enable can be 1.
REQ-028 Inputs shall be captured unmodified; no range checking or BCD conversion is performed.
REQ-029 Width rule: counters are 16 bit, and all comparisons are unsigned.

Reset
REQ-030 While reset=1, the following shall hold: div=0, column=0, row=0, pixel_tick=0, frame_start=0, snapshot outputs=0.
REQ-031 While reset=1, the decoded outputs shall be hsync=1, vsync=1, enable=1, since (0,0) is a visible position.
REQ-032 Reset assertion mid-frame shall take effect immediately (asynchronously), without waiting for a clk edge.
REQ-033 After reset release, the first pixel_tick shall occur on the CLK_DIV-th rising clk edge.

Verification
REQ-034 Line timing (CLK_DIV=2), free-run from reset: hsync low for 192 clks; hsync period 1600 clks; enable high for 1280 clks per visible line.
REQ-035 Frame timing: vsync low for 2 lines (3200 clks); frame_start period 840000 clks; exactly 480 lines with enable pulses per frame.
REQ-036 Wrap boundary: at (799,524) the next tick gives (0,0), frame_start=1 for 1 clk, and enable=1.
REQ-037 Snapshot: change minutes_in 12->13 at row 100 -> minutes stays 12 until the tick entering row 480, then becomes 13, and stays stable through the next visible region.
REQ-038 Reset mid-operation: assert reset at (400,300) -> outputs reach REQ-030/REQ-031 values without a clk edge; after release, column=1 after 2 clks.
REQ-039 CLK_DIV=1: pixel_tick stays at 1 continuously, and the hsync period is 800 clks.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the video-timing generator's data-side signals.
//   *_in            : live chronometer time, driven by the clock keeper
//   column, row     : current pixel / line counters (16 bit)
//   enable          : visible-area flag
//   hsync, vsync    : active-low sync pulses
//   pixel_tick      : one-clk strobe on each counter advance
//   frame_start     : one-clk pulse while the counters sit at (0,0) after a wrap
//   hours..milliseconds : frame-stable snapshot of the *_in values
// Modports:
//   master : the timing generator (reads *_in, drives everything else)
//   slave  : the consumer side (drives *_in, reads timing and snapshot)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [3:0]  hours_in;
  logic [5:0]  minutes_in;
  logic [5:0]  seconds_in;
  logic [9:0]  milliseconds_in;

  logic [15:0] column;
  logic [15:0] row;
  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        pixel_tick;
  logic        frame_start;

  logic [3:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic [9:0]  milliseconds;

  modport master (
    input  hours_in, minutes_in, seconds_in, milliseconds_in,
    output column, row, enable, hsync, vsync, pixel_tick, frame_start,
    output hours, minutes, seconds, milliseconds
  );

  modport slave (
    output hours_in, minutes_in, seconds_in, milliseconds_in,
    input  column, row, enable, hsync, vsync, pixel_tick, frame_start,
    input  hours, minutes, seconds, milliseconds
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with a frame-stable chronometer snapshot.
//   clk   : system clock (single domain)
//   reset : asynchronous, active-high
//   vga   : vga_timing_gen_if.master -- time inputs in, raster timing and
//           snapshot out
// A clock divider (CLK_DIV = 1..4 input clocks per pixel) produces
// pixel_tick; column/row advance on each tick and wrap at the totals.
// Sync and enable are pure decodes of the counter registers. The time
// snapshot reloads only when the raster enters vertical blank, so the
// drawer never sees the value change mid-image.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic            clk,
  input  logic            reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [2:0]  DIV_LAST   = 3'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS      = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS      = 16'(V_VISIBLE);
  localparam logic [15:0] V_VIS_LAST = 16'(V_VISIBLE - 1);
  localparam logic [15:0] HS_START   = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END     = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END     = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [2:0]  div;
  logic [15:0] column;
  logic [15:0] row;
  logic        tick;
  logic        col_last;
  logic        row_last;
  logic        snap_load;
  logic        frame_start;
  logic [3:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic [9:0]  milliseconds;

  // NOTE: with CLK_DIV=1 the divider never leaves 0, so the strobe is gated
  // by reset directly; otherwise it would read 1 while reset is held.
  assign tick      = (div == DIV_LAST) && !reset;
  assign col_last  = (column == H_LAST);
  assign row_last  = (row == V_LAST);
  assign snap_load = tick && col_last && (row == V_VIS_LAST);

  // Pixel-clock divider: 0 .. CLK_DIV-1, then wrap.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 3'd1;
    end
  end

  // Raster counters: advance only on pixel_tick, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      column <= '0;
      row    <= '0;
    end else if (tick) begin
      if (col_last) begin
        column <= '0;
        row    <= row_last ? 16'd0 : row + 16'd1;
      end else begin
        column <= column + 16'd1;
      end
    end
  end

  // Registered so it is high during the first clock spent at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && col_last && row_last;
    end
  end

  // Time snapshot: loads on the tick that enters vertical blank, so the
  // values stay put for the whole next visible region.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours        <= '0;
      minutes      <= '0;
      seconds      <= '0;
      milliseconds <= '0;
    end else if (snap_load) begin
      hours        <= vga.hours_in;
      minutes      <= vga.minutes_in;
      seconds      <= vga.seconds_in;
      milliseconds <= vga.milliseconds_in;
    end
  end

  assign vga.column       = column;
  assign vga.row          = row;
  assign vga.pixel_tick   = tick;
  assign vga.frame_start  = frame_start;
  assign vga.enable       = (column < H_VIS) && (row < V_VIS);
  assign vga.hsync        = !((column >= HS_START) && (column < HS_END));
  assign vga.vsync        = !((row >= VS_START) && (row < VS_END));
  assign vga.hours        = hours;
  assign vga.minutes      = minutes;
  assign vga.seconds      = seconds;
  assign vga.milliseconds = milliseconds;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// dut_a: CLK_DIV=2 with a shrunken raster (16x11) so whole frames are short.
// dut_b: CLK_DIV=1 with the default 800-pixel line.
// Expected outputs come from a tick-count model (column/row derived from the
// number of elapsed ticks) and are queued per clock, then popped and compared
// after each rising edge. Line/frame timing is also measured independently.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int D  = 2;
  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;   // 16
  localparam int VT = VV + VF + VS + VB;   // 11

  typedef struct {
    logic [15:0] column;
    logic [15:0] row;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        tick;
    logic        fs;
    logic [3:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [9:0]  ms;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen #(
    .CLK_DIV(D),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .vga(vif_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .vga(vif_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: state after n rising edges since reset release.
  function automatic exp_t model(input int n);
    exp_t e;
    int t, c, r;
    t = n / D;
    c = t % HT;
    r = (t / HT) % VT;
    e.column = 16'(c);
    e.row    = 16'(r);
    e.enable = (c < HV) && (r < VV);
    e.hsync  = !((c >= HV + HF) && (c < HV + HF + HS));
    e.vsync  = !((r >= VV + VF) && (r < VV + VF + VS));
    e.tick   = ((n % D) == D - 1);
    e.fs     = (t > 0) && ((n % D) == 0) && ((t % (HT * VT)) == 0);
    e.h = '0; e.m = '0; e.s = '0; e.ms = '0;
    return e;
  endfunction

  exp_t        sb_q[$];
  logic        checking = 1'b0;
  int          n_edges;
  logic [3:0]  cur_h,  snap_h;
  logic [5:0]  cur_m,  snap_m;
  logic [5:0]  cur_s,  snap_s;
  logic [9:0]  cur_ms, snap_ms;

  // Called at a falling edge: drive inputs, queue the expectation for the
  // coming rising edge, then wait for the next falling edge.
  task automatic drive_cycle();
    exp_t e;
    int   nx, t;
    vif_a.hours_in        = cur_h;
    vif_a.minutes_in      = cur_m;
    vif_a.seconds_in      = cur_s;
    vif_a.milliseconds_in = cur_ms;
    nx = n_edges + 1;
    if ((nx % D) == 0) begin
      t = nx / D;
      if ((t % HT) == 0 && ((t / HT) % VT) == VV) begin
        snap_h = cur_h; snap_m = cur_m; snap_s = cur_s; snap_ms = cur_ms;
      end
    end
    e = model(nx);
    e.h = snap_h; e.m = snap_m; e.s = snap_s; e.ms = snap_ms;
    sb_q.push_back(e);
    n_edges  = nx;
    checking = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (checking) begin
      exp_t e;
      #2;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("column",       vif_a.column,       e.column);
        check("row",          vif_a.row,          e.row);
        check("enable",       vif_a.enable,       e.enable);
        check("hsync",        vif_a.hsync,        e.hsync);
        check("vsync",        vif_a.vsync,        e.vsync);
        check("pixel_tick",   vif_a.pixel_tick,   e.tick);
        check("frame_start",  vif_a.frame_start,  e.fs);
        check("hours",        vif_a.hours,        e.h);
        check("minutes",      vif_a.minutes,      e.m);
        check("seconds",      vif_a.seconds,      e.s);
        check("milliseconds", vif_a.milliseconds, e.ms);
      end
    end
  end

  // Independent line/frame timing measurement, sampled on falling edges.
  logic measuring = 1'b0;
  int   cyc, hs_run, hs_low, hs_fall, hs_period, en_run, en_len;
  int   vs_run, vs_low, fs_last, fs_period, en_lines, lines_per_frame;
  int   b_fall, b_period, b_tick_low;
  logic p_hs, p_en, p_bhs;

  task automatic start_measure();
    cyc = 0; hs_run = 0; hs_low = -1; hs_fall = -1; hs_period = -1;
    en_run = 0; en_len = -1; vs_run = 0; vs_low = -1;
    fs_last = -1; fs_period = -1; en_lines = 0; lines_per_frame = -1;
    b_fall = -1; b_period = -1; b_tick_low = 0;
    p_hs = 1'b1; p_en = 1'b1; p_bhs = 1'b1;
    measuring = 1'b1;
  endtask

  always @(negedge clk) begin
    if (measuring) begin
      cyc++;
      if (!vif_a.hsync) hs_run++;
      else if (hs_run > 0) begin hs_low = hs_run; hs_run = 0; end
      if (p_hs && !vif_a.hsync) begin
        if (hs_fall >= 0) hs_period = cyc - hs_fall;
        hs_fall = cyc;
      end
      if (vif_a.enable) en_run++;
      else if (en_run > 0) begin en_len = en_run; en_run = 0; end
      if (!vif_a.vsync) vs_run++;
      else if (vs_run > 0) begin vs_low = vs_run; vs_run = 0; end
      if (vif_a.frame_start) begin
        if (fs_last >= 0) begin
          fs_period       = cyc - fs_last;
          lines_per_frame = en_lines;
        end
        fs_last  = cyc;
        en_lines = 0;
      end
      if (!p_en && vif_a.enable) en_lines++;
      if (!vif_b.pixel_tick) b_tick_low++;
      if (p_bhs && !vif_b.hsync) begin
        if (b_fall >= 0) b_period = cyc - b_fall;
        b_fall = cyc;
      end
      p_hs  = vif_a.hsync;
      p_en  = vif_a.enable;
      p_bhs = vif_b.hsync;
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_column"},      vif_a.column,       32'd0);
    check({pfx, "_row"},         vif_a.row,          32'd0);
    check({pfx, "_tick"},        vif_a.pixel_tick,   32'd0);
    check({pfx, "_frame_start"}, vif_a.frame_start,  32'd0);
    check({pfx, "_hsync"},       vif_a.hsync,        32'd1);
    check({pfx, "_vsync"},       vif_a.vsync,        32'd1);
    check({pfx, "_enable"},      vif_a.enable,       32'd1);
    check({pfx, "_hours"},       vif_a.hours,        32'd0);
    check({pfx, "_minutes"},     vif_a.minutes,      32'd0);
    check({pfx, "_seconds"},     vif_a.seconds,      32'd0);
    check({pfx, "_ms"},          vif_a.milliseconds, 32'd0);
    check({pfx, "_b_tick"},      vif_b.pixel_tick,   32'd0);
    check({pfx, "_b_column"},    vif_b.column,       32'd0);
  endtask

  task automatic restart_model();
    n_edges = 0;
    snap_h = '0; snap_m = '0; snap_s = '0; snap_ms = '0;
    sb_q.delete();
  endtask

  initial begin
    exp_t st;
    int   frame;
    cur_h = 4'd5; cur_m = 6'd12; cur_s = 6'd42; cur_ms = 10'd999;
    vif_a.hours_in = cur_h; vif_a.minutes_in = cur_m;
    vif_a.seconds_in = cur_s; vif_a.milliseconds_in = cur_ms;
    vif_b.hours_in = 4'd9; vif_b.minutes_in = 6'd59;
    vif_b.seconds_in = 6'd0; vif_b.milliseconds_in = 10'd1;
    restart_model();

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // Phase 1: run to a mid-frame position, then reset asynchronously.
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      st = model(n_edges);
      if (st.column == 16'd5 && st.row == 16'd3) break;
      drive_cycle();
    end
    check("pre_reset_column", vif_a.column, 32'd5);
    check("pre_reset_row",    vif_a.row,    32'd3);
    #1;
    checking = 1'b0;
    reset = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);

    // Phase 2: free-run several frames with model and timing measurement.
    restart_model();
    reset = 1'b0;
    start_measure();
    for (int i = 0; i < 1800; i++) begin
      drive_cycle();
      st    = model(n_edges);
      frame = (n_edges / D) / (HT * VT);
      if (n_edges == 2) check("col_after_2clk", vif_a.column, 32'd1);
      if (frame == 1 && st.row == 16'd2 && cur_m == 6'd12) begin
        cur_m  = 6'd13;
        cur_ms = 10'd123;
      end
      if (frame == 1 && st.row == 16'(VV - 1) && st.column == 16'(HT - 1))
        check("snap_hold_pre_blank", vif_a.minutes, 32'd12);
      if (frame == 1 && st.row == 16'(VV) && st.column == 16'd0) begin
        check("snap_load_minutes", vif_a.minutes,      32'd13);
        check("snap_load_ms",      vif_a.milliseconds, 32'd123);
      end
      if (frame == 2 && st.row == 16'd4 && st.column == 16'd3)
        check("snap_stable_visible", vif_a.minutes, 32'd13);
    end
    check("sb_drain", sb_q.size(), 32'd0);
    checking  = 1'b0;
    measuring = 1'b0;

    check("hsync_low_clks",   hs_low,          HS * D);
    check("hsync_period",     hs_period,       HT * D);
    check("enable_line_clks", en_len,          HV * D);
    check("vsync_low_clks",   vs_low,          VS * HT * D);
    check("frame_period",     fs_period,       HT * VT * D);
    check("lines_per_frame",  lines_per_frame, VV);
    check("div1_tick_low",    b_tick_low,      32'd0);
    check("div1_hsync_period", b_period,       32'd800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
